// File: rtl/serial_parity_checker_if.sv
// rtl/serial_parity_checker_if.sv - line-side and result-side signal bundle for serial_parity_checker
//
// Purpose: groups the serial line inputs and the decoded-word outputs so the
//          checker and its driver share one connection.
// Signals:
//   rx_valid   - qualifies rx_bit; a bit is consumed only when high
//   rx_bit     - serial line bit
//   data_out   - last received word, bit 0 = first data bit received
//   data_valid - one-cycle pulse when a frame completes
//   parity_err - parity mismatch for the word in data_out
//   frame_err  - stop bit was 0 for the word in data_out
//   busy       - a frame is in progress
//   err_count  - saturating count of frames with any error
// Modports: master drives the line and observes results; slave is the checker.
interface serial_parity_checker_if #(
  parameter int DATA_W = 3,
  parameter int CNT_W  = 8
);
  logic              rx_valid;
  logic              rx_bit;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output rx_valid,
    output rx_bit,
    input  data_out,
    input  data_valid,
    input  parity_err,
    input  frame_err,
    input  busy,
    input  err_count
  );

  modport slave (
    input  rx_valid,
    input  rx_bit,
    output data_out,
    output data_valid,
    output parity_err,
    output frame_err,
    output busy,
    output err_count
  );
endinterface

// File: rtl/serial_parity_checker.sv
// rtl/serial_parity_checker.sv - serial frame receiver with parity and framing check
//
// Purpose: receives start bit, DATA_W data bits (LSB first), a parity bit and
//          a stop bit, one bit per cycle with rx_valid high. Rebuilds the word,
//          checks parity with a running XOR, checks the stop bit, and reports
//          the result with a one-cycle data_valid pulse. Error flags are held
//          until the next frame completes; err_count saturates.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset, clears all state
//   bus - serial_parity_checker_if slave (rx_valid, rx_bit in; data_out,
//         data_valid, parity_err, frame_err, busy, err_count out)
module serial_parity_checker #(
  parameter int DATA_W     = 3,
  parameter bit ODD_PARITY = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_parity_checker_if.slave bus
);

  localparam int BIT_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]     CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0]    shift_q;
  logic [BIT_CNT_W-1:0] cnt_q;
  logic                 par_q;
  logic [DATA_W-1:0]    data_out_q;
  logic                 data_valid_q;
  logic                 parity_err_q;
  logic                 frame_err_q;
  logic [CNT_W-1:0]     err_count_q;

  // Per-edge strobes decoded from the state and the qualified bit.
  logic start;
  logic take_data;
  logic take_par;
  logic finish;
  logic frame_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    take_data = 1'b0;
    take_par  = 1'b0;
    finish    = 1'b0;
    if (bus.rx_valid) begin
      case (state_q)
        IDLE: begin
          // A qualified 1 is idle line and is simply dropped.
          if (!bus.rx_bit) begin
            start   = 1'b1;
            state_d = DATA;
          end
        end
        DATA: begin
          take_data = 1'b1;
          if (cnt_q == LAST_BIT) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          take_par = 1'b1;
          state_d  = STOP;
        end
        STOP: begin
          finish  = 1'b1;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // In STOP the running XOR already holds the mismatch result, because it was
  // preloaded with the required parity sense.
  assign frame_bad = par_q | ~bus.rx_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q      <= '0;
      cnt_q        <= '0;
      par_q        <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_count_q  <= '0;
    end else begin
      data_valid_q <= finish;

      if (start) begin
        cnt_q <= '0;
        par_q <= ODD_PARITY;
      end

      if (take_data) begin
        // Indexed write places data bit k at position k without a shift.
        shift_q[cnt_q] <= bus.rx_bit;
        par_q          <= par_q ^ bus.rx_bit;
        cnt_q          <= cnt_q + BIT_CNT_W'(1);
      end

      if (take_par) begin
        par_q <= par_q ^ bus.rx_bit;
      end

      if (finish) begin
        data_out_q   <= shift_q;
        parity_err_q <= par_q;
        frame_err_q  <= ~bus.rx_bit;
        if (frame_bad && (err_count_q != CNT_MAX)) begin
          err_count_q <= err_count_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// tb/tb_serial_parity_checker.sv - self-checking bench for serial_parity_checker
module tb_serial_parity_checker;

  localparam int DW = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_parity_checker_if #(.DATA_W(DW), .CNT_W(8)) ifa ();
  serial_parity_checker_if #(.DATA_W(DW), .CNT_W(2)) ifb ();

  serial_parity_checker #(.DATA_W(DW), .ODD_PARITY(1'b0), .CNT_W(8)) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(ifa)
  );

  serial_parity_checker #(.DATA_W(DW), .ODD_PARITY(1'b1), .CNT_W(2)) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(ifb)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [DW-1:0] data;
    bit            par;
    bit            stop;
    int            stall;
    int            lead;
    logic [DW-1:0] e_data;
    bit            e_pe;
    bit            e_fe;
    int            e_cnt;
  } vec_t;

  vec_t tbl[6];
  int   exp_sat[5];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int f_do(input int w);
    return (w == 0) ? int'(ifa.data_out) : int'(ifb.data_out);
  endfunction
  function automatic int f_dv(input int w);
    return (w == 0) ? int'(ifa.data_valid) : int'(ifb.data_valid);
  endfunction
  function automatic int f_pe(input int w);
    return (w == 0) ? int'(ifa.parity_err) : int'(ifb.parity_err);
  endfunction
  function automatic int f_fe(input int w);
    return (w == 0) ? int'(ifa.frame_err) : int'(ifb.frame_err);
  endfunction
  function automatic int f_busy(input int w);
    return (w == 0) ? int'(ifa.busy) : int'(ifb.busy);
  endfunction
  function automatic int f_cnt(input int w);
    return (w == 0) ? int'(ifa.err_count) : int'(ifb.err_count);
  endfunction

  // Drive one cycle on instance w; returns at the following falling edge.
  task automatic cyc(input int w, input bit v, input bit b);
    if (w == 0) begin
      ifa.rx_valid = v;
      ifa.rx_bit   = b;
    end else begin
      ifb.rx_valid = v;
      ifb.rx_bit   = b;
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input int w, input logic [DW-1:0] data, input bit p,
                            input bit s, input int stall, input int lead);
    logic [DW+2:0] bits;
    bits = {s, p, data, 1'b0};
    for (int i = 0; i < lead; i++) begin
      cyc(w, 1'b1, 1'b1);
      check("idle_busy", f_busy(w), 0);
    end
    for (int i = 0; i < DW + 3; i++) begin
      for (int j = 0; j < stall; j++) cyc(w, 1'b0, 1'($urandom_range(0, 1)));
      cyc(w, 1'b1, bits[i]);
      if (i == 0) begin
        check("start_busy", f_busy(w), 1);
        check("start_dv_low", f_dv(w), 0);
      end
    end
    check("stop_dv", f_dv(w), 1);
  endtask

  // Reference model state for the randomized phase (instance A).
  int            q[$];
  logic [DW-1:0] m_do;
  bit            m_dv, m_pe, m_fe;
  int            m_cnt;

  task automatic model_clear();
    q.delete();
    m_do  = '0;
    m_dv  = 1'b0;
    m_pe  = 1'b0;
    m_fe  = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_step(input bit v, input bit b);
    int d;
    m_dv = 1'b0;
    if (v) begin
      if (q.size() != 0 || b == 1'b0) q.push_back(int'(b));
      if (q.size() == DW + 3) begin
        d = 0;
        for (int k = 0; k < DW; k++) d += q[1 + k] << k;
        m_do = DW'(d);
        m_pe = ((($countones(d) + q[DW + 1]) % 2) != 0);
        m_fe = (q[DW + 2] == 0);
        m_dv = 1'b1;
        if ((m_pe || m_fe) && m_cnt < 255) m_cnt++;
        q.delete();
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{3'b101, 1'b0, 1'b1, 0, 0, 3'b101, 1'b0, 1'b0, 0};
    tbl[1] = '{3'b101, 1'b1, 1'b1, 0, 0, 3'b101, 1'b1, 1'b0, 1};
    tbl[2] = '{3'b011, 1'b0, 1'b1, 0, 0, 3'b011, 1'b0, 1'b0, 1};
    tbl[3] = '{3'b111, 1'b1, 1'b0, 0, 0, 3'b111, 1'b0, 1'b1, 2};
    tbl[4] = '{3'b111, 1'b0, 1'b0, 0, 0, 3'b111, 1'b1, 1'b1, 3};
    tbl[5] = '{3'b110, 1'b0, 1'b1, 3, 2, 3'b110, 1'b0, 1'b0, 3};
    exp_sat = '{1, 2, 3, 3, 3};

    rst = 1'b1;
    ifa.rx_valid = 1'b0; ifa.rx_bit = 1'b0;
    ifb.rx_valid = 1'b0; ifb.rx_bit = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_data_out", f_do(0), 0);
    check("rst_dv", f_dv(0), 0);
    check("rst_pe", f_pe(0), 0);
    check("rst_fe", f_fe(0), 0);
    check("rst_busy", f_busy(0), 0);
    check("rst_cnt", f_cnt(0), 0);
    check("rst_cnt_b", f_cnt(1), 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven frames on the even-parity instance.
    for (int r = 0; r < 6; r++) begin
      send_frame(0, tbl[r].data, tbl[r].par, tbl[r].stop, tbl[r].stall, tbl[r].lead);
      check($sformatf("row%0d_data", r), f_do(0), int'(tbl[r].e_data));
      check($sformatf("row%0d_pe", r), f_pe(0), int'(tbl[r].e_pe));
      check($sformatf("row%0d_fe", r), f_fe(0), int'(tbl[r].e_fe));
      check($sformatf("row%0d_cnt", r), f_cnt(0), tbl[r].e_cnt);
      check($sformatf("row%0d_busy_stop", r), f_busy(0), 0);
      cyc(0, 1'b0, 1'b0);
      check($sformatf("row%0d_dv_drop", r), f_dv(0), 0);
      check($sformatf("row%0d_data_hold", r), f_do(0), int'(tbl[r].e_data));
      check($sformatf("row%0d_pe_hold", r), f_pe(0), int'(tbl[r].e_pe));
    end

    // Back-to-back frames: second start bit lands right after the stop bit.
    send_frame(0, 3'b100, 1'b1, 1'b1, 0, 0);
    check("b2b_first_data", f_do(0), 4);
    send_frame(0, 3'b001, 1'b1, 1'b1, 0, 0);
    check("b2b_second_data", f_do(0), 1);
    check("b2b_pe", f_pe(0), 0);
    check("b2b_cnt", f_cnt(0), 3);
    cyc(0, 1'b0, 1'b0);

    // Reset after two data bits: asynchronous clear, no pulse afterwards.
    cyc(0, 1'b1, 1'b0);
    cyc(0, 1'b1, 1'b1);
    cyc(0, 1'b1, 1'b1);
    ifa.rx_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", f_busy(0), 0);
    check("midrst_data", f_do(0), 0);
    check("midrst_dv", f_dv(0), 0);
    check("midrst_cnt", f_cnt(0), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 1'b0, 1'b0);
    check("midrst_no_pulse", f_dv(0), 0);
    send_frame(0, 3'b010, 1'b1, 1'b1, 0, 0);
    check("postrst_data", f_do(0), 2);
    check("postrst_pe", f_pe(0), 0);
    check("postrst_fe", f_fe(0), 0);
    check("postrst_cnt", f_cnt(0), 0);
    cyc(0, 1'b0, 1'b0);

    // Odd-parity instance with a 2-bit counter.
    send_frame(1, 3'b000, 1'b1, 1'b1, 0, 0);
    check("odd_good_pe", f_pe(1), 0);
    check("odd_good_cnt", f_cnt(1), 0);
    cyc(1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      send_frame(1, 3'b000, 1'b0, 1'b1, 0, 0);
      check($sformatf("sat%0d_pe", i), f_pe(1), 1);
      check($sformatf("sat%0d_fe", i), f_fe(1), 0);
      check($sformatf("sat%0d_cnt", i), f_cnt(1), exp_sat[i]);
      cyc(1, 1'b0, 1'b0);
    end

    // Randomized traffic on instance A against the frame-level model.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    for (int c = 0; c < 4000; c++) begin
      int act;
      int exp;
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        ifa.rx_valid = 1'b0;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
      end else begin
        bit v;
        bit b;
        v = ($urandom_range(0, 3) != 0);
        b = ($urandom_range(0, 9) < 6);
        model_step(v, b);
        cyc(0, v, b);
      end
      act = (f_do(0) << 12) | (f_dv(0) << 11) | (f_pe(0) << 10) | (f_fe(0) << 9)
          | (f_busy(0) << 8) | f_cnt(0);
      exp = (int'(m_do) << 12) | (int'(m_dv) << 11) | (int'(m_pe) << 10)
          | (int'(m_fe) << 9) | ((q.size() != 0 ? 1 : 0) << 8) | m_cnt;
      check($sformatf("rand_c%0d", c), act, exp);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
